console_in: RTL and testbench

CONSOLE_IN -- requirements
Module: console_in

---
 rtl/console_in_if.sv | 22 ++
 rtl/console_in.sv | 112 +++++++++++
 tb/tb_console_in.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/console_in_if.sv
// Bus and host-character signals of the console RX block.
// The slave modport faces the block; the master modport faces the CPU/host side.
interface console_in_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        src_valid_i;
    logic [7:0]  src_data_i;
    logic        irq_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, src_valid_i, src_data_i,
        output rdata_o, irq_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, src_valid_i, src_data_i,
        input  rdata_o, irq_o
    );
endinterface

// File: rtl/console_in.sv
// Console receive path: host characters land in a FIFO that the CPU drains
// through RX_DATA, with status/control registers and a level interrupt.
module console_in #(
    parameter int unsigned Depth  = 8,
    parameter int unsigned CountW = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    console_in_if.slave  bus
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [7:0] AddrData   = 8'h00;
    localparam logic [7:0] AddrStatus = 8'h04;
    localparam logic [7:0] AddrCtrl   = 8'h08;
    localparam logic [CountW-1:0] CountFull = CountW'(Depth);

    logic [7:0]        mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CountW-1:0] count;
    logic              overflow;
    logic              irq_en;
    logic [31:0]       rdata;
    logic              irq;

    logic        rd_c;
    logic        ctrl_wr_c;
    logic        not_empty_c;
    logic        full_c;
    logic        pop_c;
    logic        push_c;
    logic        flush_c;
    logic        clr_ov_c;
    logic        set_ov_c;
    logic [31:0] status_c;
    logic [31:0] rdata_c;
    logic        unused_bits;

    // Only the low address byte and the three control bits are meaningful.
    assign unused_bits = ^{bus.addr_i[31:8], bus.wdata_i[31:3]};

    // Access decode, FIFO push/pop arbitration and read-data mux.
    always_comb begin
        rd_c        = 1'b0;
        ctrl_wr_c   = 1'b0;
        pop_c       = 1'b0;
        push_c      = 1'b0;
        flush_c     = 1'b0;
        clr_ov_c    = 1'b0;
        set_ov_c    = 1'b0;
        rdata_c     = 32'h0;
        not_empty_c = (count != '0);
        full_c      = (count == CountFull);

        rd_c      = bus.req_i & ~bus.we_i;
        ctrl_wr_c = bus.req_i & bus.we_i & (bus.addr_i[7:0] == AddrCtrl);
        flush_c   = ctrl_wr_c & bus.wdata_i[0];
        clr_ov_c  = ctrl_wr_c & bus.wdata_i[1];
        pop_c     = rd_c & (bus.addr_i[7:0] == AddrData) & not_empty_c;

        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push_c   = bus.src_valid_i & ~flush_c & (~full_c | pop_c);
        set_ov_c = bus.src_valid_i & ~flush_c & full_c & ~pop_c;

        status_c      = 32'(count) << 8;
        status_c[3:0] = {irq_en, overflow, full_c, not_empty_c};

        unique case (bus.addr_i[7:0])
            AddrData:   rdata_c = not_empty_c ? {23'h0, 1'b1, mem[rd_ptr]} : 32'h0;
            AddrStatus: rdata_c = status_c;
            AddrCtrl:   rdata_c = {29'h0, irq_en, 2'b00};
            default:    rdata_c = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            rdata    <= 32'h0;
            irq      <= 1'b0;
        end else begin
            if (flush_c) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PtrW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PtrW'(1);
                count <= count + CountW'(push_c) - CountW'(pop_c);
            end

            if (set_ov_c)      overflow <= 1'b1;
            else if (clr_ov_c) overflow <= 1'b0;

            if (ctrl_wr_c) irq_en <= bus.wdata_i[2];
            if (rd_c)      rdata  <= rdata_c;
            irq <= irq_en & not_empty_c;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_c) mem[wr_ptr] <= bus.src_data_i;
    end

    assign bus.rdata_o = rdata;
    assign bus.irq_o   = irq;
endmodule

// File: tb/tb_console_in.sv
// Bench for console_in: directed vector table, hand-written corner sequences
// and a randomized run, all checked against a queue-based reference model.
module tb_console_in;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    console_in_if bus_if ();

    console_in #(.Depth(DEPTH), .CountW(9)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the FIFO is just a queue of characters.
    logic [7:0]  q[$];
    bit          ov_m;
    bit          ien_m;
    logic [31:0] rd_m;
    bit          irq_m;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          sv;
        logic [7:0]  sd;
        bit          chk;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ov_m  = 0;
        ien_m = 0;
        rd_m  = 32'h0;
        irq_m = 0;
    endtask

    task automatic model_step(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] wd, input bit v, input logic [7:0] d);
        logic [7:0] off;
        int  sz;
        bit  pop, flush, clr, setov;
        off   = a[7:0];
        sz    = q.size();
        irq_m = ien_m && (sz != 0);
        if (r && !w) begin
            case (off)
                8'h00:   rd_m = (sz != 0) ? (32'h100 | 32'(q[0])) : 32'h0;
                8'h04:   rd_m = (32'(sz) << 8) | (32'(ien_m) << 3) | (32'(ov_m) << 2)
                              | (32'(sz == DEPTH) << 1) | 32'(sz != 0);
                8'h08:   rd_m = 32'(ien_m) << 2;
                default: rd_m = 32'h0;
            endcase
        end
        flush = r && w && off == 8'h08 && wd[0];
        clr   = r && w && off == 8'h08 && wd[1];
        pop   = r && !w && off == 8'h00 && sz > 0;
        setov = 0;
        if (flush) q.delete();
        else begin
            if (pop) q.delete(0);
            if (v) begin
                if (q.size() < DEPTH) q.push_back(d);
                else setov = 1;
            end
        end
        if (setov)    ov_m = 1;
        else if (clr) ov_m = 0;
        if (r && w && off == 8'h08) ien_m = wd[2];
    endtask

    // One clock: drive, advance the model, sample just after the edge.
    task automatic cycle(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit v, input logic [7:0] d);
        bus_if.req_i       = r;
        bus_if.we_i        = w;
        bus_if.addr_i      = a;
        bus_if.wdata_i     = wd;
        bus_if.src_valid_i = v;
        bus_if.src_data_i  = d;
        if (rst) model_reset();
        else     model_step(r, w, a, wd, v, d);
        @(posedge clk);
        #1;
        check("model_rdata", bus_if.rdata_o, rd_m);
        check("model_irq", 32'(bus_if.irq_o), 32'(irq_m));
    endtask

    task automatic push(input logic [7:0] d);
        cycle(0, 0, 0, 0, 1, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1, 0, a, 0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        cycle(1, 1, a, wd, 0, 0);
    endtask

    function automatic void add(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] wd, input bit v, input logic [7:0] d,
                                input bit chk, input logic [31:0] er, input bit ei);
        tbl.push_back('{r, w, a, wd, v, d, chk, er, ei});
    endfunction

    initial begin
        logic [31:0] ra;
        bus_if.req_i = 0; bus_if.we_i = 0; bus_if.addr_i = 0; bus_if.wdata_i = 0;
        bus_if.src_valid_i = 0; bus_if.src_data_i = 0;
        rst = 0;
        model_reset();
        #2 rst = 1;
        #1;
        check("reset_rdata", bus_if.rdata_o, 32'h0);
        check("reset_irq", 32'(bus_if.irq_o), 32'h0);
        cycle(1, 0, 0, 0, 1, 8'h11);
        cycle(0, 0, 0, 0, 1, 8'h12);
        rst = 0;

        // Directed table: two chars, overflow fill, interrupt enable.
        add(0,0,32'h00,0,0,8'h00, 1,32'h000,0);
        add(0,0,32'h00,0,1,8'h41, 1,32'h000,0);
        add(0,0,32'h00,0,1,8'h42, 0,32'h000,0);
        add(1,0,32'h00,0,0,8'h00, 1,32'h141,0);
        add(1,0,32'h00,0,0,8'h00, 1,32'h142,0);
        add(1,0,32'h00,0,0,8'h00, 1,32'h000,0);
        for (int i = 0; i < 9; i++) add(0,0,32'h00,0,1,8'(8'h10 + i), 0,32'h0,0);
        add(1,0,32'h04,0,0,8'h00, 1,32'h807,0);
        for (int i = 0; i < 8; i++) add(1,0,32'h00,0,0,8'h00, 1,32'h110 + 32'(i),0);
        add(1,0,32'h00,0,0,8'h00, 1,32'h000,0);
        add(1,1,32'h08,32'h2,0,8'h00, 0,32'h0,0);
        add(1,0,32'h04,0,0,8'h00, 1,32'h000,0);
        add(1,1,32'h08,32'h4,0,8'h00, 0,32'h0,0);
        add(0,0,32'h00,0,1,8'h78, 0,32'h0,0);
        add(0,0,32'h00,0,0,8'h00, 0,32'h0,1);
        add(1,0,32'h00,0,0,8'h00, 1,32'h178,1);
        add(0,0,32'h00,0,0,8'h00, 0,32'h0,0);
        add(1,0,32'h08,0,0,8'h00, 1,32'h004,0);
        add(1,1,32'h08,32'h0,0,8'h00, 0,32'h0,0);
        add(1,0,32'h1FC,0,0,8'h00, 1,32'h000,0);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sv, tbl[i].sd);
            if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), bus_if.rdata_o, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), 32'(bus_if.irq_o), 32'(tbl[i].exp_irq));
        end

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        cycle(1, 0, 32'h00, 0, 1, 8'h5A);
        check("full_pushpop_head", bus_if.rdata_o, 32'h120);
        rd(32'h04);
        check("full_pushpop_status", bus_if.rdata_o, 32'h803);
        for (int i = 1; i < 8; i++) rd(32'h00);
        check("full_pushpop_7th", bus_if.rdata_o, 32'h127);
        rd(32'h00);
        check("full_pushpop_8th", bus_if.rdata_o, 32'h15A);

        // Empty FIFO with simultaneous push and pop.
        cycle(1, 0, 32'h00, 0, 1, 8'h33);
        check("empty_pushpop", bus_if.rdata_o, 32'h0);
        rd(32'h00);
        check("empty_pushpop_next", bus_if.rdata_o, 32'h133);

        // Flush racing a push.
        push(8'h61); push(8'h62); push(8'h63);
        cycle(1, 1, 32'h08, 32'h1, 1, 8'h99);
        rd(32'h04);
        check("flush_status", bus_if.rdata_o, 32'h0);
        rd(32'h00);
        check("flush_data", bus_if.rdata_o, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = 32'h00;
                2:       ra = 32'h04;
                3:       ra = 32'h08;
                4:       ra = 32'h104;
                default: ra = $urandom;
            endcase
            cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), ra,
                  {$urandom, ($urandom_range(0, 7) == 0)} >> 0 & 32'hFFFF_FFF8
                      | 32'($urandom_range(0, 6) & 6) | 32'($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 6), 8'($urandom));
        end

        // Asynchronous reset with characters pending and overflow set.
        wr(32'h08, 32'h7);
        for (int i = 0; i < 9; i++) push(8'(8'h50 + i));
        rd(32'h00);
        check("prerst_data", bus_if.rdata_o, 32'h150);
        check("prerst_irq", 32'(bus_if.irq_o), 32'h1);
        #3 rst = 1;
        model_reset();
        #1;
        check("async_rst_rdata", bus_if.rdata_o, 32'h0);
        check("async_rst_irq", 32'(bus_if.irq_o), 32'h0);
        @(posedge clk);
        #1;
        cycle(1, 0, 32'h00, 0, 1, 8'h77);
        cycle(1, 1, 32'h08, 32'h4, 1, 8'h78);
        rst = 0;
        rd(32'h04);
        check("postrst_status", bus_if.rdata_o, 32'h0);
        rd(32'h00);
        check("postrst_data", bus_if.rdata_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
